// File: rtl/menu_button_pixel_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : menu_pkg
// Brief    : Colour constants, button FSM state encoding, menu ROM code names
//            and the synthetic menu bitmap image.
// Revision : 1.0 - initial release
// ============================================================================
package menu_pkg;

    localparam logic [11:0] c_black  = 12'h000;
    localparam logic [11:0] c_white  = 12'hFFF;
    localparam logic [11:0] c_touch  = 12'h32E;
    localparam logic [11:0] c_click  = 12'h3E2;
    localparam logic [11:0] c_locked = 12'h567;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_hover = 2'd1;
    localparam logic [1:0] c_press = 2'd2;

    localparam logic [1:0] c_code_bg  = 2'd0;
    localparam logic [1:0] c_code_fg  = 2'd1;
    localparam logic [1:0] c_code_btn = 2'd2;
    localparam logic [1:0] c_code_fg2 = 2'd3;

    // Image code = sum of all 2-bit address digits, modulo 4.
    function automatic logic [1:0] rom_image(input logic [18:0] addr);
        logic [19:0] w_ext;
        logic [1:0]  w_code;
        w_ext  = {1'b0, addr};
        w_code = 2'd0;
        for (int k = 0; k < 10; k++) begin
            w_code = w_code + w_ext[2*k +: 2];
        end
        return w_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/menu_button_pixel_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : menu_button_pixel_gen_if
// Brief     : VGA counters, mouse state, button lock/hover/click and pixel bus.
// Revision  : 1.0 - initial release
// ============================================================================
interface menu_button_pixel_gen_if #(
    parameter int NUM_BUTTONS = 2
);
    logic [9:0]             h_cnt;
    logic [9:0]             v_cnt;
    logic [9:0]             mouse_x;
    logic [9:0]             mouse_y;
    logic                   mouse_left;
    logic [NUM_BUTTONS-1:0] btn_lock;
    logic [NUM_BUTTONS-1:0] btn_hover;
    logic [NUM_BUTTONS-1:0] btn_click;
    logic [11:0]            pixel_out;

    modport master (
        output h_cnt, v_cnt, mouse_x, mouse_y, mouse_left, btn_lock,
        input  btn_hover, btn_click, pixel_out
    );

    modport slave (
        input  h_cnt, v_cnt, mouse_x, mouse_y, mouse_left, btn_lock,
        output btn_hover, btn_click, pixel_out
    );
endinterface
`default_nettype wire

// File: rtl/menu_button_pixel_gen_fsm.sv
`default_nettype none
// ============================================================================
// Module   : menu_button_fsm
// Brief    : Per-button press tracker: IDLE/HOVER/PRESS with registered hover
//            and one-cycle click on press-and-release inside the button.
// Revision : 1.0 - initial release
// ============================================================================
module menu_button_fsm
    import menu_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_in,
    input  wire logic       i_left,
    input  wire logic       i_lock,
    output logic      [1:0] o_state,
    output logic            o_hover,
    output logic            o_click
);
    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_click;
    logic       r_hover;
    logic       r_click;

    always_comb begin
        w_next  = r_state;
        w_click = 1'b0;
        case (r_state)
            c_idle: begin
                // A press that began outside the button never arms it.
                if (i_in && !i_left) w_next = c_hover;
            end
            c_hover: begin
                if (!i_in)       w_next = c_idle;
                else if (i_left) w_next = c_press;
            end
            c_press: begin
                if (!i_left) begin
                    w_next  = i_in ? c_hover : c_idle;
                    w_click = i_in;
                end
            end
            default: w_next = c_idle;
        endcase
        if (i_lock) begin
            w_next  = c_idle;
            w_click = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_hover <= 1'b0;
            r_click <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hover <= i_in && !i_lock;
            r_click <= w_click;
        end
    end

    assign o_state = r_state;
    assign o_hover = r_hover;
    assign o_click = r_click;
endmodule
`default_nettype wire

// File: rtl/menu_button_pixel_gen_rom.sv
`default_nettype none
// ============================================================================
// Module   : Menu_Mem_Gen
// Brief    : Behavioural stand-in for the menu bitmap block ROM: fixed image,
//            ROM_LAT-clock read latency, no reset (like the hard block).
// Revision : 1.0 - initial release
// ============================================================================
module Menu_Mem_Gen
    import menu_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  wire logic        clka,
    input  wire logic [18:0] addra,
    output logic      [1:0]  douta
);
    logic [1:0] r_pipe [ROM_LAT];

    always_ff @(posedge clka) begin
        r_pipe[0] <= rom_image(addra);
        for (int k = 1; k < ROM_LAT; k++) begin
            r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign douta = r_pipe[ROM_LAT-1];
endmodule
`default_nettype wire

// File: rtl/menu_button_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : menu_button_pixel_gen
// Brief    : Menu-screen pixel generator for N stacked buttons with per-button
//            press FSMs, hover/click outputs and ROM_LAT+1 pixel latency.
// Revision : 1.0 - initial release
// ============================================================================
module menu_button_pixel_gen
    import menu_pkg::*;
#(
    parameter int NUM_BUTTONS = 2,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ROM_LAT     = 1,
    parameter int BTN_X0      = 220,
    parameter int BTN_W       = 200,
    parameter int BTN_Y0      = 250,
    parameter int BTN_H       = 50,
    parameter int BTN_PITCH   = 60
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    menu_button_pixel_gen_if.slave  bus
);
    logic [18:0]            w_addr;
    logic                   w_active;
    logic [18:0]            r_addr;
    logic [9:0]             r_v_pipe [ROM_LAT+1];
    logic [ROM_LAT:0]       r_act_pipe;
    logic [1:0]             w_douta;
    logic [9:0]             w_v_al;
    logic                   w_x_in;
    logic [NUM_BUTTONS-1:0] w_in;
    logic [NUM_BUTTONS-1:0] w_vband;
    logic [NUM_BUTTONS-1:0] w_hover;
    logic [NUM_BUTTONS-1:0] w_click;
    logic [1:0]             w_state [NUM_BUTTONS];
    logic [11:0]            w_band_col;
    logic [11:0]            w_pixel;
    logic [11:0]            r_pixel;

    assign w_addr   = 19'(bus.h_cnt) + 19'(H_RES) * 19'(bus.v_cnt);
    assign w_active = (32'(bus.h_cnt) < H_RES) && (32'(bus.v_cnt) < V_RES);

    // Stage 0 feeds the ROM; v/active then ride ROM_LAT delays to meet douta.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_act_pipe <= '0;
            r_pixel    <= c_black;
            for (int k = 0; k <= ROM_LAT; k++) begin
                r_v_pipe[k] <= '0;
            end
        end else begin
            r_addr        <= w_addr;
            r_v_pipe[0]   <= bus.v_cnt;
            r_act_pipe[0] <= w_active;
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_v_pipe[k]   <= r_v_pipe[k-1];
                r_act_pipe[k] <= r_act_pipe[k-1];
            end
            r_pixel <= w_pixel;
        end
    end

    Menu_Mem_Gen #(
        .ROM_LAT (ROM_LAT)
    ) u_rom (
        .clka  (clk),
        .addra (r_addr),
        .douta (w_douta)
    );

    assign w_v_al = r_v_pipe[ROM_LAT];
    assign w_x_in = (32'(bus.mouse_x) >= BTN_X0) && (32'(bus.mouse_x) < BTN_X0 + BTN_W);

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        localparam int c_top = BTN_Y0 + gi * BTN_PITCH;

        assign w_in[gi]    = w_x_in && (32'(bus.mouse_y) >= c_top)
                                    && (32'(bus.mouse_y) < c_top + BTN_H);
        assign w_vband[gi] = (32'(w_v_al) >= c_top) && (32'(w_v_al) < c_top + BTN_H);

        menu_button_fsm u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_in    (w_in[gi]),
            .i_left  (bus.mouse_left),
            .i_lock  (bus.btn_lock[gi]),
            .o_state (w_state[gi]),
            .o_hover (w_hover[gi]),
            .o_click (w_click[gi])
        );
    end

    // Bands never overlap, so at most one iteration hits; state is read live.
    always_comb begin
        w_band_col = c_black;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (w_vband[i]) begin
                if (bus.btn_lock[i])           w_band_col = c_locked;
                else if (w_state[i] == c_press) w_band_col = c_click;
                else if (w_state[i] == c_hover) w_band_col = c_touch;
                else                            w_band_col = c_black;
            end
        end

        w_pixel = c_black;
        if (r_act_pipe[ROM_LAT]) begin
            case (w_douta)
                c_code_btn:            w_pixel = w_band_col;
                c_code_fg, c_code_fg2: w_pixel = c_white;
                default:               w_pixel = c_black;
            endcase
        end
    end

    assign bus.pixel_out = r_pixel;
    assign bus.btn_hover = w_hover;
    assign bus.btn_click = w_click;
endmodule
`default_nettype wire

// File: tb/tb_menu_button_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_button_pixel_gen
// Brief    : Two DUTs (2 buttons/ROM_LAT 1 and 4 buttons/ROM_LAT 3) on shared
//            stimulus, checked each cycle against a behavioural menu model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_menu_button_pixel_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] h_cnt = '0, v_cnt = '0, mouse_x = '0, mouse_y = '0;
    logic       mouse_left = 1'b0;
    logic [3:0] lock = '0;

    menu_button_pixel_gen_if #(.NUM_BUTTONS(2)) bus_a ();
    menu_button_pixel_gen_if #(.NUM_BUTTONS(4)) bus_b ();

    assign bus_a.h_cnt = h_cnt;     assign bus_b.h_cnt = h_cnt;
    assign bus_a.v_cnt = v_cnt;     assign bus_b.v_cnt = v_cnt;
    assign bus_a.mouse_x = mouse_x; assign bus_b.mouse_x = mouse_x;
    assign bus_a.mouse_y = mouse_y; assign bus_b.mouse_y = mouse_y;
    assign bus_a.mouse_left = mouse_left; assign bus_b.mouse_left = mouse_left;
    assign bus_a.btn_lock = lock[1:0];    assign bus_b.btn_lock = lock;

    menu_button_pixel_gen #(.NUM_BUTTONS(2), .ROM_LAT(1)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a));
    menu_button_pixel_gen #(.NUM_BUTTONS(4), .ROM_LAT(3)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { bit rst; int h; int v; } rec_t;
    rec_t       hist[$];
    bit         armed [4];
    bit         held  [4];
    bit         model_ready = 1'b0;
    logic [11:0] exp_pix_a, exp_pix_b;
    logic [3:0]  exp_hover, exp_click;

    function automatic int rom_code(int h, int v);
        int a = h + 640 * v;
        int s = 0;
        while (a > 0) begin
            s += a % 4;
            a /= 4;
        end
        return s % 4;
    endfunction

    // Button index whose vertical band holds y, or -1.
    function automatic int band_of(int y, int n);
        int dy = y - 250;
        if (dy < 0 || dy % 60 >= 50 || dy / 60 >= n) return -1;
        return dy / 60;
    endfunction

    function automatic bit hit(int i);
        return (mouse_x >= 220) && (mouse_x < 420) && (band_of(int'(mouse_y), 4) == i);
    endfunction

    function automatic logic [11:0] colour(int h, int v, int n);
        int c, b;
        if (h >= 640 || v >= 480) return 12'h000;
        c = rom_code(h, v);
        if (c == 0) return 12'h000;
        if (c != 2) return 12'hFFF;
        b = band_of(v, n);
        if (b < 0)   return 12'h000;
        if (lock[b]) return 12'h567;
        if (held[b]) return 12'h3E2;
        if (armed[b]) return 12'h32E;
        return 12'h000;
    endfunction

    function automatic logic [11:0] expect_pixel(int lat, int n);
        int sz = hist.size();
        if (sz < lat + 2) return 12'h000;
        for (int k = 0; k <= lat + 1; k++)
            if (hist[sz-1-k].rst) return 12'h000;
        return colour(hist[sz-1-(lat+1)].h, hist[sz-1-(lat+1)].v, n);
    endfunction

    always @(posedge clk) begin
        rec_t r;
        bit   in_i;
        r.rst = !rst_n; r.h = int'(h_cnt); r.v = int'(v_cnt);
        hist.push_back(r);
        if (hist.size() > 8) void'(hist.pop_front());
        exp_pix_a = expect_pixel(1, 2);
        exp_pix_b = expect_pixel(3, 4);
        for (int i = 0; i < 4; i++) begin
            in_i = hit(i);
            if (!rst_n) begin
                exp_hover[i] = 1'b0; exp_click[i] = 1'b0;
                armed[i] = 1'b0; held[i] = 1'b0;
            end else begin
                exp_hover[i] = in_i && !lock[i];
                exp_click[i] = held[i] && !mouse_left && in_i && !lock[i];
                if (lock[i]) begin
                    armed[i] = 1'b0; held[i] = 1'b0;
                end else if (held[i]) begin
                    if (!mouse_left) begin held[i] = 1'b0; armed[i] = in_i; end
                end else if (armed[i]) begin
                    if (!in_i) armed[i] = 1'b0;
                    else if (mouse_left) begin armed[i] = 1'b0; held[i] = 1'b1; end
                end else begin
                    armed[i] = in_i && !mouse_left;
                end
            end
        end
        model_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("pixel_a", int'(bus_a.pixel_out), int'(exp_pix_a));
            check("pixel_b", int'(bus_b.pixel_out), int'(exp_pix_b));
            check("hover_a", int'(bus_a.btn_hover), int'(exp_hover[1:0]));
            check("hover_b", int'(bus_b.btn_hover), int'(exp_hover));
            check("click_a", int'(bus_a.btn_click), int'(exp_click[1:0]));
            check("click_b", int'(bus_b.btn_click), int'(exp_click));
        end
    end

    // ---------------- stimulus + literal pins ----------------
    int clicks_a = 0, clicks_b = 0;

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            clicks_a += $countones(bus_a.btn_click);
            clicks_b += $countones(bus_b.btn_click);
        end
    endtask

    task automatic mouse(int x, int y, bit l);
        mouse_x = 10'(x); mouse_y = 10'(y); mouse_left = l;
    endtask

    task automatic pix(int h, int v);
        h_cnt = 10'(h); v_cnt = 10'(v);
    endtask

    task automatic pin_pixels(string name, int exp);
        check({name, "_a"}, int'(bus_a.pixel_out), exp);
        check({name, "_b"}, int'(bus_b.pixel_out), exp);
    endtask

    initial begin
        // Reset with the button held over button 0.
        rst_n = 1'b0; mouse(300, 270, 1'b1); pix(1, 270);
        cyc(4);
        pin_pixels("reset_pixel", 0);
        check("reset_hover", int'(bus_a.btn_hover), 0);
        check("reset_click", int'(bus_b.btn_click), 0);
        rst_n = 1'b1;
        cyc(6);
        check("held_through_reset_hover", int'(bus_a.btn_hover), 1);
        pin_pixels("held_through_reset_not_armed", 12'h000);

        // Click on button 0.
        mouse(300, 270, 1'b0); cyc(6);
        pin_pixels("click_touch", 12'h32E);
        mouse_left = 1'b1; cyc(3);
        pin_pixels("click_pressed", 12'h3E2);
        clicks_a = 0; clicks_b = 0;
        mouse_left = 1'b0; cyc(4);
        check("click_count_a", clicks_a, 1);
        check("click_count_b", clicks_b, 1);
        pin_pixels("click_after", 12'h32E);

        // Drag out of button 1, then drag into button 0.
        mouse(300, 330, 1'b0); cyc(2);
        mouse_left = 1'b1; cyc(2);
        mouse(300, 100, 1'b1); cyc(2);
        clicks_a = 0; clicks_b = 0;
        mouse_left = 1'b0; cyc(3);
        check("drag_out_clicks", clicks_a + clicks_b, 0);
        mouse(100, 100, 1'b1); cyc(2);
        mouse(300, 270, 1'b1); cyc(3);
        clicks_a = 0; clicks_b = 0;
        mouse_left = 1'b0; cyc(3);
        check("drag_in_clicks", clicks_a + clicks_b, 0);
        check("drag_in_hover", int'(bus_a.btn_hover), 1);

        // Lock button 1 while pressed.
        pix(3, 310);
        mouse(300, 330, 1'b0); cyc(2);
        mouse_left = 1'b1; cyc(2);
        lock = 4'b0010; cyc(2);
        clicks_a = 0; clicks_b = 0;
        mouse_left = 1'b0; cyc(6);
        check("lock_clicks", clicks_a + clicks_b, 0);
        check("lock_hover", int'(bus_a.btn_hover), 0);
        pin_pixels("lock_colour", 12'h567);
        lock = 4'b0000; cyc(2);

        // Hit-test edges.
        mouse(419, 270, 1'b0); cyc(2);
        check("edge_x419", int'(bus_a.btn_hover), 1);
        mouse(420, 270, 1'b0); cyc(2);
        check("edge_x420", int'(bus_a.btn_hover), 0);
        mouse(220, 299, 1'b0); cyc(2);
        check("edge_x220_y299", int'(bus_a.btn_hover), 1);
        mouse(300, 300, 1'b0); cyc(2);
        check("edge_y300", int'(bus_a.btn_hover), 0);

        // Pixel literals and inactive region.
        pix(700, 0); cyc(6); pin_pixels("inactive", 12'h000);
        pix(1, 0);   cyc(6); pin_pixels("white_code", 12'hFFF);
        pix(0, 0);   cyc(6); pin_pixels("black_code", 12'h000);

        // Line sweep at v=0.
        for (int h = 0; h < 640; h++) begin
            pix(h, 0); cyc(1);
        end
        pix(700, 0); cyc(6);

        // Randomised run.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) != 0) pix($urandom_range(0, 700), $urandom_range(230, 500));
            else                           pix($urandom_range(0, 1023), $urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0)
                mouse($urandom_range(200, 440), $urandom_range(230, 500), mouse_left);
            if ($urandom_range(0, 4) == 0) mouse_left = ~mouse_left;
            if ($urandom_range(0, 49) == 0) lock[$urandom_range(0, 3)] ^= 1'b1;
            rst_n = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
